sdram_req_queue: RTL and testbench

SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

---
 rtl/sdram_pkg.sv | 40 ++++
 rtl/sdram_req_fifo.sv | 72 +++++++
 rtl/sdram_req_queue.sv | 211 +++++++++++++++++++++
 tb/tb_sdram_req_queue.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared types for the SDRAM request queue. Holds the issue
//               FSM state encoding, the read/write command encoding and the
//               request-entry struct. The address is carried next to the
//               struct because its width is a parameter of the queue.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  localparam int DATA_WIDTH = 16;

  // Issue FSM states
  typedef enum logic [1:0] {
    Q_IDLE  = 2'd0,
    Q_ISSUE = 2'd1,
    Q_BUSY  = 2'd2
  } q_state_e;

  // Request command encoding
  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  // Request entry (address travels alongside in the FIFO word)
  typedef struct packed {
    cmd_e                  cmd;
    logic [DATA_WIDTH-1:0] wdata;
  } req_entry_t;

  localparam int ENTRY_WIDTH = $bits(req_entry_t);

  function automatic cmd_e cmd_from_we(input logic we);
    return we ? CMD_WR : CMD_RD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdram_req_fifo
// Description : In-order request FIFO, no bypass. Pointers are log2(DEPTH)
//               bits and wrap naturally; full/empty come from a separate
//               occupancy counter one bit wider.
// Ports       : clk, rst_n       - clock, async active-low reset
//               push, push_data  - write side (ignored when full)
//               pop, pop_data    - read side, pop_data is the current head
//               full, empty      - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  // Storage carries no reset: contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : sdram_req_queue
// Description : Host request queue in front of an SDRAM controller. Requests
//               are buffered in an in-order FIFO and issued one at a time;
//               read data is returned as a one-cycle rsp_valid pulse.
// Ports       : req_*            - host request channel (valid/ready)
//               rsp_valid/data   - read response, no backpressure
//               wr_*/rd_*        - SDRAM controller host interface
//               busy, rd_ready   - controller status inputs
//               stat_rd/wr_cnt   - completed read/write counters
// Config      : define SDRAM_REQ_QUEUE_STATS_EN to build the statistics
//               counters; otherwise they are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH = 24,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // host request channel
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]            req_wdata,
  // read response
  output logic                   rsp_valid,
  output logic [15:0]            rsp_data,
  // controller host interface
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic [15:0]            rd_data,
  input  logic                   rd_ready,
  input  logic                   busy,
  // statistics
  output logic [15:0]            stat_rd_cnt,
  output logic [15:0]            stat_wr_cnt
);

  localparam int FIFO_W = HADDR_WIDTH + ENTRY_WIDTH;

  q_state_e               r_state;
  q_state_e               w_state_nxt;
  logic                   r_ready_en;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  req_entry_t             w_push_entry;
  logic [FIFO_W-1:0]      w_push_word;
  logic [FIFO_W-1:0]      w_pop_word;
  req_entry_t             r_entry;
  logic [HADDR_WIDTH-1:0] r_addr;
  logic                   r_rsp_taken;
  logic                   w_rd_capture;
  logic                   r_rsp_valid;
  logic [15:0]            r_rsp_data;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  assign w_push_entry.cmd   = cmd_from_we(req_we);
  assign w_push_entry.wdata = req_wdata;
  assign w_push_word        = {req_addr, w_push_entry};

  // r_ready_en holds req_ready low during reset and for the release cycle.
  assign req_ready = r_ready_en && !w_full;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == Q_IDLE) && !w_empty;

  sdram_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_word),
    .pop       (w_pop),
    .pop_data  (w_pop_word),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Issue register: the single request outstanding at the controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '0;
      r_addr  <= '0;
    end else if (w_pop) begin
      r_entry <= req_entry_t'(w_pop_word[ENTRY_WIDTH-1:0]);
      r_addr  <= w_pop_word[FIFO_W-1 -: HADDR_WIDTH];
    end
  end

  assign rd_addr = r_addr;
  assign wr_addr = r_addr;
  assign wr_data = r_entry.wdata;

  // --------------------------------------------------------------------------
  // Issue FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= Q_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      Q_IDLE:  if (!w_empty) w_state_nxt = Q_ISSUE;
      // Enables stay up through refresh/init for as long as busy stays low.
      Q_ISSUE: if (busy)     w_state_nxt = Q_BUSY;
      Q_BUSY:  if (!busy)    w_state_nxt = Q_IDLE;
      default:               w_state_nxt = Q_IDLE;
    endcase
  end

  always_comb begin
    rd_enable = 1'b0;
    wr_enable = 1'b0;
    if (r_state == Q_ISSUE) begin
      if (r_entry.cmd == CMD_WR) begin
        wr_enable = 1'b1;
      end else begin
        rd_enable = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read response: capture on rd_ready during a read's busy window, pulse
  // rsp_valid the cycle after. r_rsp_taken limits each read to one response.
  // --------------------------------------------------------------------------
  assign w_rd_capture = (r_state == Q_BUSY) && (r_entry.cmd == CMD_RD) &&
                        rd_ready && !r_rsp_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_taken <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rd_capture;
      if (w_rd_capture) begin
        r_rsp_data <= rd_data;
      end
      if (w_pop) begin
        r_rsp_taken <= 1'b0;
      end else if (w_rd_capture) begin
        r_rsp_taken <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef SDRAM_REQ_QUEUE_STATS_EN
  logic [15:0] r_stat_rd_cnt;
  logic [15:0] r_stat_wr_cnt;
  logic        w_wr_done;

  assign w_wr_done = (r_state == Q_BUSY) && !busy && (r_entry.cmd == CMD_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_rd_cnt <= '0;
      r_stat_wr_cnt <= '0;
    end else begin
      if (r_rsp_valid) begin
        r_stat_rd_cnt <= r_stat_rd_cnt + 16'd1;
      end
      if (w_wr_done) begin
        r_stat_wr_cnt <= r_stat_wr_cnt + 16'd1;
      end
    end
  end

  assign stat_rd_cnt = r_stat_rd_cnt;
  assign stat_wr_cnt = r_stat_wr_cnt;
`else
  assign stat_rd_cnt = 16'd0;
  assign stat_wr_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdram_req_queue
// Description : Directed self-checking bench for sdram_req_queue. The bench
//               plays the SDRAM controller by driving busy/rd_ready/rd_data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_req_queue;

`ifdef SDRAM_REQ_QUEUE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_enable;
  logic [23:0] rd_addr;
  logic        rd_enable;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic        busy;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_wr_cnt;

  int compared   = 0;
  int mismatched = 0;
  int excl_viol  = 0;

  sdram_req_queue #(.HADDR_WIDTH(24), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_enable   (wr_enable),
    .rd_addr     (rd_addr),
    .rd_enable   (rd_enable),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .busy        (busy),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
  );

  always #5 clk = ~clk;

  // Both enables high together is never legal.
  always @(negedge clk) begin
    if (rst_n && rd_enable && wr_enable) excl_viol++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Controller stand-in: waits for an enable, records it, then runs a short
  // busy window (rd_ready on its last cycle for reads) and counts responses.
  task automatic serve(input logic [15:0] rdval, output bit tmo, output bit was_rd,
                       output bit was_wr, output logic [23:0] addr,
                       output logic [15:0] wdata, output int rsp_n,
                       output logic [15:0] rsp_d);
    int n;
    n = 0; tmo = 1'b0; was_rd = 1'b0; was_wr = 1'b0; addr = '0; wdata = '0;
    rsp_n = 0; rsp_d = '0;
    while (!(rd_enable || wr_enable) && n < 40) begin
      tick();
      n++;
    end
    if (!(rd_enable || wr_enable)) begin
      tmo = 1'b1;
      return;
    end
    was_rd = rd_enable; was_wr = wr_enable;
    addr   = rd_enable ? rd_addr : wr_addr;
    wdata  = wr_data;
    busy = 1'b1;
    tick();
    if (rsp_valid) rsp_n++;
    rd_ready = was_rd; rd_data = rdval;
    tick();
    if (rsp_valid) begin rsp_n++; rsp_d = rsp_data; end
    busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
    tick();
    if (rsp_valid) rsp_n++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
    @(negedge clk);
    compared++;
    if ({req_ready, rd_enable, wr_enable, rsp_valid} !== 4'b0 || rsp_data !== 16'h0 ||
        rd_addr !== 24'h0 || wr_addr !== 24'h0 || wr_data !== 16'h0 ||
        stat_rd_cnt !== 16'h0 || stat_wr_cnt !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: rdy=%0b re=%0b we=%0b rv=%0b rsp=%h ra=%h wa=%h wd=%h sr=%h sw=%h, required all 0",
               req_ready, rd_enable, wr_enable, rsp_valid, rsp_data, rd_addr, wr_addr, wr_data,
               stat_rd_cnt, stat_wr_cnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_ready: req_ready=%0b required 0 before first edge", req_ready);
    end
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready_rise: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic test_read();
    int bad;
    do_reset();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h012345; req_wdata = 16'h0;
    tick();                       // accepting edge
    req_valid = 1'b0;
    compared++;
    if (rd_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL read_lat_early: rd_enable=%0b required 0 one cycle after accept", rd_enable);
    end
    tick();                       // pop edge, enable visible now
    compared++;
    if (rd_enable !== 1'b1 || wr_enable !== 1'b0 || rd_addr !== 24'h012345) begin
      mismatched++;
      $display("FAIL read_issue: re=%0b we=%0b addr=%h required 1/0/012345", rd_enable, wr_enable, rd_addr);
    end
    tick();                       // busy still 0: enable must hold
    compared++;
    if (rd_enable !== 1'b1) begin
      mismatched++;
      $display("FAIL read_hold: rd_enable=%0b required 1 while busy=0", rd_enable);
    end
    busy = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin rd_ready = 1'b1; rd_data = 16'hBEEF; end
      tick();
      if (i < 5 && (rd_enable !== 1'b0 || rsp_valid !== 1'b0)) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL read_busy_window: %0d bad cycles, required 0 (enable/rsp low)", bad);
    end
    busy = 1'b0; rd_ready = 1'b0; rd_data = 16'h0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL read_rsp: rsp_valid=%0b rsp_data=%h required 1/BEEF", rsp_valid, rsp_data);
    end
    tick();
    compared++;
    if (rsp_valid !== 1'b0 || rd_enable !== 1'b0 || stat_rd_cnt !== 16'(STATS)) begin
      mismatched++;
      $display("FAIL read_after: rsp_valid=%0b rd_enable=%0b stat_rd=%0d required 0/0/%0d",
               rsp_valid, rd_enable, stat_rd_cnt, STATS);
    end
  endtask

  task automatic test_write_read();
    bit tmo, is_rd, is_wr; logic [23:0] a; logic [15:0] wd, rd; int n;
    do_reset();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h000010; req_wdata = 16'hA5A5;
    tick();
    req_we = 1'b0; req_wdata = 16'h0;
    tick();
    req_valid = 1'b0;
    serve(16'h5A5A, tmo, is_rd, is_wr, a, wd, n, rd);
    compared++;
    if (tmo || !is_wr || is_rd || a !== 24'h000010 || wd !== 16'hA5A5 || n != 0) begin
      mismatched++;
      $display("FAIL wr_first: tmo=%0b wr=%0b rd=%0b addr=%h wdata=%h rsp=%0d required 0/1/0/000010/A5A5/0",
               tmo, is_wr, is_rd, a, wd, n);
    end
    serve(16'h5A5A, tmo, is_rd, is_wr, a, wd, n, rd);
    compared++;
    if (tmo || !is_rd || is_wr || a !== 24'h000010 || n != 1 || rd !== 16'h5A5A) begin
      mismatched++;
      $display("FAIL rd_second: tmo=%0b rd=%0b wr=%0b addr=%h rsp=%0d data=%h required 0/1/0/000010/1/5A5A",
               tmo, is_rd, is_wr, a, n, rd);
    end
    compared++;
    if (stat_wr_cnt !== 16'(STATS) || stat_rd_cnt !== 16'(STATS)) begin
      mismatched++;
      $display("FAIL wr_rd_stats: wr=%0d rd=%0d required %0d/%0d", stat_wr_cnt, stat_rd_cnt, STATS, STATS);
    end
  endtask

  task automatic test_back_to_back();
    bit tmo, is_rd, is_wr; logic [23:0] a; logic [15:0] wd, rd; int n, extra;
    do_reset();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000111; req_wdata = 16'h0;
    tick();
    req_we = 1'b1; req_addr = 24'h000222; req_wdata = 16'h1234;
    tick();                       // push and pop on the same edge
    req_valid = 1'b0;
    serve(16'h0F0F, tmo, is_rd, is_wr, a, wd, n, rd);
    compared++;
    if (tmo || !is_rd || a !== 24'h000111 || n != 1 || rd !== 16'h0F0F) begin
      mismatched++;
      $display("FAIL b2b_first: tmo=%0b rd=%0b addr=%h rsp=%0d data=%h required 0/1/000111/1/0F0F",
               tmo, is_rd, a, n, rd);
    end
    serve(16'h0, tmo, is_rd, is_wr, a, wd, n, rd);
    compared++;
    if (tmo || !is_wr || a !== 24'h000222 || wd !== 16'h1234) begin
      mismatched++;
      $display("FAIL b2b_second: tmo=%0b wr=%0b addr=%h wdata=%h required 0/1/000222/1234",
               tmo, is_wr, a, wd);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_enable || wr_enable) extra++;
    end
    compared++;
    if (extra != 0) begin
      mismatched++;
      $display("FAIL b2b_no_extra: %0d enable cycles after drain, required 0", extra);
    end
  endtask

  task automatic test_full();
    bit tmo, is_rd, is_wr; logic [23:0] a; logic [15:0] wd, rd; int n, bad, extra;
    do_reset();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h0000A0; req_wdata = 16'h0;
    tick();
    req_valid = 1'b0;
    tick();                       // A0 in ISSUE
    busy = 1'b1;
    tick();                       // A0 in BUSY, queue parked
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h0000B0 + 24'(i); req_wdata = 16'h00B0 + 16'(i);
      if (req_ready !== 1'b1) bad++;
      tick();
    end
    req_valid = 1'b0;
    compared++;
    if (bad != 0 || req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_after4: ready_miss=%0d req_ready=%0b required 0/0", bad, req_ready);
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h0000B5; req_wdata = 16'h00B5;
    tick();
    busy = 1'b0;
    tick();                       // FSM back to IDLE, still full
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_hold: req_ready=%0b required 0 while full", req_ready);
    end
    tick();                       // pop of B1
    compared++;
    if (req_ready !== 1'b1 || wr_enable !== 1'b1 || wr_addr !== 24'h0000B1) begin
      mismatched++;
      $display("FAIL full_pop: ready=%0b wr_en=%0b addr=%h required 1/1/0000B1", req_ready, wr_enable, wr_addr);
    end
    tick();                       // B5 accepted
    req_valid = 1'b0;
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_refill: req_ready=%0b required 0 (count 4)", req_ready);
    end
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      serve(16'h0, tmo, is_rd, is_wr, a, wd, n, rd);
      if (tmo || !is_wr || a !== 24'h0000B0 + 24'(i) || wd !== 16'h00B0 + 16'(i)) bad++;
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_enable || wr_enable) extra++;
    end
    compared++;
    if (bad != 0 || extra != 0) begin
      mismatched++;
      $display("FAIL full_drain: %0d wrong issues, %0d extra enables, required 0/0", bad, extra);
    end
  endtask

  task automatic test_refresh();
    bit tmo, is_rd, is_wr; logic [23:0] a; logic [15:0] wd, rd; int n, bad, extra;
    do_reset();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h0ABCDE; req_wdata = 16'h0;
    tick();
    req_valid = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_enable !== 1'b1 || wr_enable !== 1'b0 || rd_addr !== 24'h0ABCDE) bad++;
      tick();
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL refresh_hold: %0d unstable cycles, required 0", bad);
    end
    serve(16'h7777, tmo, is_rd, is_wr, a, wd, n, rd);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_enable || wr_enable) extra++;
    end
    compared++;
    if (tmo || !is_rd || n != 1 || rd !== 16'h7777 || extra != 0) begin
      mismatched++;
      $display("FAIL refresh_single: tmo=%0b rd=%0b rsp=%0d data=%h extra=%0d required 0/1/1/7777/0",
               tmo, is_rd, n, rd, extra);
    end
  endtask

  task automatic test_reset_midflight();
    int n, bad;
    do_reset();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h055555; req_wdata = 16'h0;
    tick();
    req_addr = 24'h066666;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rd_enable && n < 40) begin tick(); n++; end
    busy = 1'b1;
    tick();                       // read in BUSY
    rd_ready = 1'b1; rd_data = 16'hDEAD;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({req_ready, rd_enable, wr_enable, rsp_valid} !== 4'b0 || rsp_data !== 16'h0 ||
        rd_addr !== 24'h0 || wr_addr !== 24'h0 || wr_data !== 16'h0 ||
        stat_rd_cnt !== 16'h0 || stat_wr_cnt !== 16'h0) begin
      mismatched++;
      $display("FAIL async_reset: rdy=%0b re=%0b we=%0b rv=%0b rsp=%h ra=%h wa=%h wd=%h required all 0",
               req_ready, rd_enable, wr_enable, rsp_valid, rsp_data, rd_addr, wr_addr, wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1; busy = 1'b0; rd_ready = 1'b0; rd_data = 16'h0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid || rd_enable || wr_enable) bad++;
    end
    compared++;
    if (bad != 0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_discard: %0d activity cycles, req_ready=%0b required 0/1", bad, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back();
    test_full();
    test_refresh();
    test_reset_midflight();
    compared++;
    if (excl_viol != 0) begin
      mismatched++;
      $display("FAIL enable_exclusive: %0d cycles with both enables, required 0", excl_viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
